// File: rtl/data_bus_responder.sv
// data_bus_responder: target end of the core's data bus.
// Decodes each bus access onto a byte-enabled data RAM or a 16-byte register
// window. The window holds a transmit FIFO that drains onto an 8-bit
// valid/ready stream, a FIFO status register and a 64-bit cycle counter.
// Read data is combinational. Writes and all state changes happen on the
// rising clock edge.
// Optional feature: define DATA_BUS_RESPONDER_CYCLE_COUNTER_EN to build the
// cycle counter and its high-word shadow. Without it, CYCLE_LO and CYCLE_HI
// stay mapped but read as zero.
module data_bus_responder #(
    parameter logic [31:0] RAM_BASE        = 32'h8000_0000,
    parameter int          RAM_WORDS_LOG2  = 10,
    parameter logic [31:0] MMIO_BASE       = 32'h1000_0000,
    parameter int          FIFO_DEPTH_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    input  logic [3:0]  bus_byte_enable,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        bus_fault
);

    localparam int RAM_WORDS  = 1 << RAM_WORDS_LOG2;
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;
    localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

    // Address decode. Subtracting the base first lets an address below the
    // base wrap to a large offset, so one unsigned compare checks both ends of
    // the window.
    logic [31:0] ram_offset;
    logic [31:0] mmio_offset;
    logic        ram_hit;
    logic        mmio_hit;
    logic        unmapped;
    logic [RAM_WORDS_LOG2-1:0] ram_index;
    logic [1:0]  reg_sel;

    assign ram_offset  = bus_address - RAM_BASE;
    assign mmio_offset = bus_address - MMIO_BASE;
    assign ram_hit     = ram_offset < RAM_BYTES;
    assign mmio_hit    = mmio_offset < 32'd16;
    assign unmapped    = !ram_hit && !mmio_hit;
    assign ram_index   = ram_offset[RAM_WORDS_LOG2+1:2];
    assign reg_sel     = mmio_offset[3:2];

    // Access strobes derived from the decode.
    logic ram_write;
    logic txdata_push;
    logic overflow_clear;
    logic any_access;

    assign ram_write      = bus_write_enable && ram_hit;
    assign txdata_push    = bus_write_enable && mmio_hit && (reg_sel == 2'd0) && bus_byte_enable[0];
    assign overflow_clear = bus_write_enable && mmio_hit && (reg_sel == 2'd1) &&
                            bus_byte_enable[0] && bus_write_data[2];
    assign any_access     = bus_read_enable || bus_write_enable;

    // Data RAM. It is not reset, so its contents are undefined until written.
    logic [31:0] ram [RAM_WORDS];

    // Byte-lane writes into the RAM. Lanes whose byte enable is clear keep
    // their old value.
    always_ff @(posedge clock) begin
        for (int n = 0; n < 4; n++) begin
            if (ram_write && bus_byte_enable[n]) begin
                ram[ram_index][8*n +: 8] <= bus_write_data[8*n +: 8];
            end
        end
    end

    // Transmit FIFO: a circular buffer. The count is one bit wider than the
    // pointers so that full and empty can be told apart.
    logic [7:0]                 fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       fifo_pop;
    logic                       push_accept;
    logic                       push_drop;
    logic                       overflow;

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == FIFO_FULL_COUNT);
    assign fifo_pop    = !fifo_empty && tx_ready;
    assign push_accept = txdata_push && (!fifo_full || fifo_pop);
    assign push_drop   = txdata_push && fifo_full && !fifo_pop;

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    // FIFO storage. A push into a full FIFO is still accepted when the head
    // leaves on the same edge.
    always_ff @(posedge clock) begin
        if (push_accept) begin
            fifo_mem[wr_ptr] <= bus_write_data[7:0];
        end
    end

    // FIFO pointers, occupancy count, overflow flag and the sticky bus fault.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            bus_fault <= 1'b0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_accept, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
            if (any_access && unmapped) begin
                bus_fault <= 1'b1;
            end
        end
    end

    logic [31:0] cycle_lo_value;
    logic [31:0] cycle_hi_value;

`ifdef DATA_BUS_RESPONDER_CYCLE_COUNTER_EN
    logic [63:0] cycle_count;
    logic [31:0] hi_shadow;
    logic        cycle_lo_read;

    assign cycle_lo_read  = bus_read_enable && mmio_hit && (reg_sel == 2'd2);
    assign cycle_lo_value = cycle_count[31:0];
    assign cycle_hi_value = hi_shadow;

    // Free-running cycle counter. A read of CYCLE_LO snapshots the upper word
    // so that a later CYCLE_HI read pairs with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= 64'd0;
            hi_shadow   <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 64'd1;
            if (cycle_lo_read) begin
                hi_shadow <= cycle_count[63:32];
            end
        end
    end
`else
    assign cycle_lo_value = 32'd0;
    assign cycle_hi_value = 32'd0;
`endif

    // Combinational read mux. It returns zero when no read is strobed or the
    // address is unmapped. A same-cycle write is not visible until the next
    // cycle.
    always_comb begin
        bus_read_data = 32'd0;
        if (bus_read_enable) begin
            if (ram_hit) begin
                bus_read_data = ram[ram_index];
            end else if (mmio_hit) begin
                case (reg_sel)
                    2'd1:    bus_read_data = {29'd0, overflow, fifo_empty, fifo_full};
                    2'd2:    bus_read_data = cycle_lo_value;
                    2'd3:    bus_read_data = cycle_hi_value;
                    default: bus_read_data = 32'd0;
                endcase
            end
        end
    end

endmodule
